game_flow_ctrl: RTL and testbench

Game-level sequencer between the pixel-rate drawing objects and the score/ship datapath. It turns per-pixel overlaps of ship, rock and shot draw requests into at most one collision event per frame. It runs the IDLE/PLAY/DYING/OVER game state machine, counts lives, times respawn and game-over, and drives `score_box` (clear/add) and `Ship_unit` (enable/collision). This replaces the raw per-pixel `draw & draw` score connection.

---
 rtl/game_flow_ctrl.sv | 119 +++++++++++
 tb/tb_game_flow_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-level game sequencer for collisions, lives, respawn and game-over timing
// Ports:
//   clk, resetN                 pixel clock, asynchronous active-low reset
//   pxl_x, pxl_y                current pixel; (0,0) entry marks the frame commit edge
//   Start                       start button level (synchronous)
//   draw_ship/rock/shot         per-pixel draw requests of the game objects
//   state, lives                game state (0 IDLE,1 PLAY,2 DYING,3 OVER) and remaining lives
//   ship_enable, ship_collision ship control and one-cycle destroy pulse
//   score_clear, score_add      one-cycle score pulses; score_sum is the per-hit amount
//   game_over                   high while in OVER
module game_flow_ctrl #(
  parameter int LIVES = 3,
  parameter int RESPAWN_FRAMES = 120,
  parameter int OVER_FRAMES = 300,
  parameter int HIT_SCORE = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  input  logic        Start,
  input  logic        draw_ship,
  input  logic        draw_rock,
  input  logic        draw_shot,
  output logic [1:0]  state,
  output logic [2:0]  lives,
  output logic        ship_enable,
  output logic        ship_collision,
  output logic        score_clear,
  output logic        score_add,
  output logic [7:0]  score_sum,
  output logic        game_over
);
  typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} state_t;
  state_t st, st_n;
  logic [9:0] cnt, cnt_n;
  logic [2:0] lives_n;
  logic ship_hit, rock_hit, ship_hit_n, rock_hit_n;
  logic origin_q, start_q, origin, commit, start_edge, live;
  logic col_n, clr_n, add_n;
  assign state = st;
  assign score_sum = 8'(HIT_SCORE);
  always_comb begin
    origin = pxl_x == '0 && pxl_y == '0;
    commit = origin && !origin_q;
    start_edge = Start && !start_q;
    live = st == PLAY || st == DYING;
    st_n = st;
    cnt_n = cnt;
    lives_n = lives;
    col_n = 1'b0;
    clr_n = 1'b0;
    add_n = commit && rock_hit && live;
    // an overlap seen on the commit edge itself belongs to the new frame
    ship_hit_n = (ship_hit && !commit) || (st == PLAY && draw_ship && draw_rock);
    rock_hit_n = (rock_hit && !commit) || (live && draw_shot && draw_rock);
    if (start_edge && (st == IDLE || st == OVER)) begin
      st_n = PLAY;
      lives_n = 3'(LIVES);
      clr_n = 1'b1;
      ship_hit_n = 1'b0;
      rock_hit_n = 1'b0;
    end else if (commit) begin
      case (st)
        PLAY: if (ship_hit) begin
          col_n = 1'b1;
          lives_n = lives - 3'(lives != 3'd0);
          st_n = lives <= 3'd1 ? OVER : DYING;
          cnt_n = lives <= 3'd1 ? 10'(OVER_FRAMES) : 10'(RESPAWN_FRAMES);
        end
        DYING: begin
          cnt_n = cnt - 10'(cnt != 10'd0);
          if (cnt <= 10'd1) begin
            st_n = PLAY;
            ship_hit_n = 1'b0;
            rock_hit_n = 1'b0;
          end
        end
        OVER: begin
          cnt_n = cnt - 10'(cnt != 10'd0);
          if (cnt <= 10'd1) begin
            st_n = IDLE;
            lives_n = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st <= IDLE;
      cnt <= '0;
      lives <= '0;
      ship_hit <= 1'b0;
      rock_hit <= 1'b0;
      origin_q <= 1'b0;
      start_q <= 1'b1;
      ship_enable <= 1'b0;
      ship_collision <= 1'b0;
      score_clear <= 1'b0;
      score_add <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      lives <= lives_n;
      ship_hit <= ship_hit_n;
      rock_hit <= rock_hit_n;
      origin_q <= origin;
      start_q <= Start;
      ship_enable <= st_n == PLAY;
      ship_collision <= col_n;
      score_clear <= clr_n;
      score_add <= add_n;
      game_over <= st_n == OVER;
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed and randomized bench for game_flow_ctrl with a behavioural game model
module tb_game_flow_ctrl;
  logic clk = 0, resetN = 0, Start = 1;
  logic draw_ship = 0, draw_rock = 0, draw_shot = 0;
  logic [31:0] pxl_x = 5, pxl_y = 5;
  logic [1:0] state;
  logic [2:0] lives;
  logic ship_enable, ship_collision, score_clear, score_add, game_over;
  logic [7:0] score_sum;
  int checks = 0, errors = 0, n_add = 0, a0;
  int m_st, m_lives, m_cnt;
  bit m_sh, m_rh, m_po, m_ps, m_add, m_col, m_clr;
  always #5 clk = ~clk;
  game_flow_ctrl #(.LIVES(3), .RESPAWN_FRAMES(120), .OVER_FRAMES(300), .HIT_SCORE(1)) dut (
    .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y), .Start(Start),
    .draw_ship(draw_ship), .draw_rock(draw_rock), .draw_shot(draw_shot),
    .state(state), .lives(lives), .ship_enable(ship_enable), .ship_collision(ship_collision),
    .score_clear(score_clear), .score_add(score_add), .score_sum(score_sum), .game_over(game_over)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset;
    m_st = 0; m_lives = 0; m_cnt = 0; m_sh = 0; m_rh = 0;
    m_po = 0; m_ps = 1; m_add = 0; m_col = 0; m_clr = 0;
  endtask
  task automatic new_game;
    m_st = 1; m_lives = 3; m_clr = 1; m_sh = 0; m_rh = 0;
  endtask
  task automatic model_edge;
    bit org, e, se, scoring, old_sh, old_rh;
    org = pxl_x == 0 && pxl_y == 0;
    e = org && !m_po;
    se = Start && !m_ps;
    scoring = m_st == 1 || m_st == 2;
    old_sh = m_sh;
    old_rh = m_rh;
    m_po = org;
    m_ps = Start;
    if (e) begin m_sh = 0; m_rh = 0; end
    if (m_st == 1 && draw_ship && draw_rock) m_sh = 1;
    if (scoring && draw_shot && draw_rock) m_rh = 1;
    m_add = e && old_rh && scoring;
    m_col = 0;
    m_clr = 0;
    if (se && (m_st == 0 || m_st == 3)) new_game;
    else if (e && m_st == 1 && old_sh) begin
      m_col = 1;
      m_lives--;
      if (m_lives == 0) begin m_st = 3; m_cnt = 300; end
      else begin m_st = 2; m_cnt = 120; end
    end else if (e && (m_st == 2 || m_st == 3)) begin
      m_cnt--;
      if (m_cnt == 0) m_st = m_st == 2 ? 1 : 0;
      if (m_cnt == 0 && m_st == 1) begin m_sh = 0; m_rh = 0; end
    end
  endtask
  task automatic check_all;
    chk("state", state, m_st);
    chk("lives", lives, m_lives);
    chk("ship_enable", ship_enable, m_st == 1);
    chk("ship_collision", ship_collision, m_col);
    chk("score_clear", score_clear, m_clr);
    chk("score_add", score_add, m_add);
    chk("game_over", game_over, m_st == 3);
    chk("score_sum", score_sum, 1);
  endtask
  task automatic tick;
    @(posedge clk);
    if (resetN) model_edge; else model_reset;
    #1;
    n_add += score_add;
    check_all;
  endtask
  task automatic e_tick;
    pxl_x = 0; pxl_y = 0;
    draw_ship = 0; draw_rock = 0; draw_shot = 0;
    tick;
  endtask
  task automatic body(int len, int ns, int nt, int rnd);
    for (int i = 1; i < len; i++) begin
      pxl_x = i % 10;
      pxl_y = i / 10;
      draw_rock = (ns + nt > 0) || (rnd > 0 && $urandom_range(0, 3) == 0);
      draw_shot = (i <= nt) || (rnd > 0 && $urandom_range(0, 3) == 0);
      draw_ship = (i <= ns) || (rnd == 2 && $urandom_range(0, 3) == 0);
      tick;
    end
    draw_ship = 0; draw_rock = 0; draw_shot = 0;
  endtask
  task automatic frames(int n, int rnd);
    repeat (n) begin e_tick; body(8, 0, 0, rnd); end
  endtask
  task automatic respawn;
    body(8, 5, 0, 0);
    e_tick;
    chk("hit_collision", ship_collision, 1);
    chk("hit_dying", state, 2);
    body(8, 0, 0, 2);
    frames(119, 2);
    e_tick;
    chk("respawn_play", state, 1);
  endtask
  task automatic last_life;
    body(8, 5, 0, 0);
    e_tick;
    chk("over_state", state, 3);
    chk("over_lives", lives, 0);
    chk("over_flag", game_over, 1);
    body(8, 0, 0, 2);
    frames(299, 2);
  endtask
  initial begin
    model_reset;
    tick; tick;
    resetN = 1;
    tick; tick; tick;
    chk("held_start_ignored", state, 0);
    Start = 0; tick;
    Start = 1; tick;
    chk("start_play", state, 1);
    chk("start_clear", score_clear, 1);
    chk("start_lives", lives, 3);
    Start = 0; tick;
    chk("clear_one_cycle", score_clear, 0);
    e_tick;
    body(60, 0, 50, 0);
    a0 = n_add;
    e_tick;
    chk("rock_add", score_add, 1);
    chk("rock_sum", score_sum, 1);
    body(8, 0, 0, 0);
    chk("one_add_per_frame", n_add - a0, 1);
    e_tick;
    chk("no_add_next_frame", score_add, 0);
    body(8, 0, 0, 0);
    pxl_x = 0; pxl_y = 0; draw_shot = 1; draw_rock = 1;
    tick;
    chk("origin_overlap_deferred", score_add, 0);
    body(8, 0, 0, 0);
    e_tick;
    chk("origin_overlap_next", score_add, 1);
    body(8, 0, 0, 1);
    frames(5, 1);
    e_tick;
    body(20, 10, 10, 0);
    e_tick;
    chk("both_collision", ship_collision, 1);
    chk("both_add", score_add, 1);
    chk("both_lives", lives, 2);
    chk("both_dying", state, 2);
    body(8, 5, 0, 0);
    e_tick;
    chk("dying_ship_ignored", ship_collision, 0);
    body(8, 0, 5, 0);
    e_tick;
    chk("dying_rock_add", score_add, 1);
    body(8, 0, 0, 2);
    frames(116, 2);
    e_tick;
    chk("dying_119", state, 2);
    body(8, 0, 0, 2);
    e_tick;
    chk("dying_120_play", state, 1);
    respawn;
    last_life;
    e_tick;
    chk("over_to_idle", state, 0);
    body(8, 0, 0, 2);
    Start = 1; tick;
    Start = 0; tick;
    chk("replay", state, 1);
    respawn;
    respawn;
    last_life;
    Start = 1;
    e_tick;
    chk("start_wins_state", state, 1);
    chk("start_wins_clear", score_clear, 1);
    chk("start_wins_lives", lives, 3);
    Start = 0;
    body(8, 0, 5, 0);
    resetN = 0;
    #2;
    model_reset;
    check_all;
    e_tick;
    chk("reset_no_pulse", score_add, 0);
    resetN = 1;
    tick;
    chk("post_reset_idle", state, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
